// File: rtl/adt7420_pkg.sv
// adt7420_pkg: shared types and constants for the ADT7420 polling sequencer.
// Holds the I2C command opcodes, the sequencer states and the register
// pointers, plus the table that maps (state, step) to the command issued.
package adt7420_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_START     = 3'd1,
        OP_RSTART    = 3'd2,
        OP_WRITE     = 3'd3,
        OP_READ_ACK  = 3'd4,
        OP_READ_NACK = 3'd5,
        OP_STOP      = 3'd6
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_POLL,
        ST_CFG,
        ST_ABORT
    } state_t;

    // Per-command handshake phase: SETUP is the single quiet cycle after a
    // state entry, CMD presents the command, RSP waits for the master's reply.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_CMD,
        PH_RSP
    } phase_t;

    localparam logic [7:0] REG_TEMP = 8'h00;
    localparam logic [7:0] REG_CFG  = 8'h03;

    // Command issued at a given step of each transaction type.
    function automatic cmd_op_t seq_op(input state_t st, input logic [2:0] step);
        cmd_op_t op;
        op = OP_NOP;
        case (st)
            ST_INIT, ST_CFG: begin
                case (step)
                    3'd0:       op = OP_START;
                    3'd1, 3'd2,
                    3'd3:       op = OP_WRITE;
                    default:    op = OP_STOP;
                endcase
            end
            ST_POLL: begin
                case (step)
                    3'd0:       op = OP_START;
                    3'd1, 3'd2: op = OP_WRITE;
                    3'd3:       op = OP_RSTART;
                    3'd4:       op = OP_WRITE;
                    3'd5:       op = OP_READ_ACK;
                    3'd6:       op = OP_READ_NACK;
                    default:    op = OP_STOP;
                endcase
            end
            ST_ABORT: op = OP_STOP;
            default:  op = OP_NOP;
        endcase
        return op;
    endfunction

    // Index of the final (STOP) step of each transaction type.
    function automatic logic [2:0] seq_last(input state_t st);
        logic [2:0] last;
        case (st)
            ST_POLL:  last = 3'd7;
            ST_ABORT: last = 3'd0;
            default:  last = 3'd4;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/interval_tick.sv
// interval_tick: free-running counter that emits a one-cycle tick every
// INTERVAL clocks. The tick is high while the count sits at INTERVAL-1, and
// the counter reloads to zero on that same cycle.
module interval_tick #(
    parameter int INTERVAL = 10000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = $clog2(INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next count: wrap at the last value, otherwise increment.
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    // Count register, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adt7420_poll_ctrl.sv
// adt7420_poll_ctrl: command sequencer in front of a byte-level I2C master.
// Configures the ADT7420 after reset, polls the temperature register every
// INTERVAL clocks and arbitrates one host config write onto the same bus.
// Optional build macro ADT7420_AVG_EN: temp_data becomes the floored mean of
// the last four samples instead of the raw reading.
module adt7420_poll_ctrl
    import adt7420_pkg::*;
#(
    parameter int         INTERVAL = 10000,
    parameter logic [6:0] I2C_ADDR = 7'h4B,
    parameter logic [7:0] CFG_INIT = 8'h80
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    input  logic        cfg_req,
    input  logic [7:0]  cfg_data,
    output logic        cfg_done,
    output logic        temp_valid,
    output logic [15:0] temp_data,
    output logic        busy,
    output logic        err
);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  step_q, step_d;
    logic        poll_pend_q, poll_pend_d;
    logic        temp_valid_q, temp_valid_d;
    logic        cfg_done_q, cfg_done_d;
    logic        err_q, err_d;
    logic [15:0] temp_data_q, temp_data_d;
    logic [7:0]  msb_q, msb_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [7:0]  cfg_byte_q, cfg_byte_d;

    logic               tick;
    logic               pend_clr;
    logic               sample_take;
    cmd_op_t            cur_op;
    logic [7:0]         cur_data;
    logic signed [15:0] raw;
    logic signed [15:0] sample_val;

    interval_tick #(
        .INTERVAL (INTERVAL)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tick_o (tick)
    );

    assign raw        = signed'({msb_q, lsb_q});
    assign cmd_valid  = (phase_q == PH_CMD);
    assign cmd_op     = cmd_valid ? cur_op : OP_NOP;
    assign cmd_data   = cmd_valid ? cur_data : 8'h00;
    assign busy       = (state_q != ST_IDLE);
    assign temp_valid = temp_valid_q;
    assign cfg_done   = cfg_done_q;
    assign err        = err_q;
    assign temp_data  = temp_data_q;

    // Command and payload byte for the current step of the transaction.
    always_comb begin
        cur_op   = seq_op(state_q, step_q);
        cur_data = 8'h00;
        case (state_q)
            ST_INIT, ST_CFG: begin
                case (step_q)
                    3'd1:    cur_data = {I2C_ADDR, 1'b0};
                    3'd2:    cur_data = REG_CFG;
                    3'd3:    cur_data = (state_q == ST_INIT) ? CFG_INIT : cfg_byte_q;
                    default: cur_data = 8'h00;
                endcase
            end
            ST_POLL: begin
                case (step_q)
                    3'd1:    cur_data = {I2C_ADDR, 1'b0};
                    3'd2:    cur_data = REG_TEMP;
                    3'd4:    cur_data = {I2C_ADDR, 1'b1};
                    default: cur_data = 8'h00;
                endcase
            end
            default: cur_data = 8'h00;
        endcase
    end

    // Sequencer: arbitration in IDLE, one outstanding command otherwise.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        poll_pend_d  = poll_pend_q;
        msb_d        = msb_q;
        lsb_d        = lsb_q;
        cfg_byte_d   = cfg_byte_q;
        temp_data_d  = temp_data_q;
        temp_valid_d = 1'b0;
        cfg_done_d   = 1'b0;
        err_d        = 1'b0;
        sample_take  = 1'b0;
        pend_clr     = 1'b0;

        if (state_q == ST_IDLE) begin
            // A request still visible on the cfg_done cycle is the one just served.
            if (cfg_req && !cfg_done_q) begin
                state_d    = ST_CFG;
                phase_d    = PH_SETUP;
                step_d     = 3'd0;
                cfg_byte_d = cfg_data;
            end else if (poll_pend_q) begin
                state_d  = ST_POLL;
                phase_d  = PH_SETUP;
                step_d   = 3'd0;
                pend_clr = 1'b1;
            end
        end else begin
            case (phase_q)
                PH_SETUP: phase_d = PH_CMD;
                PH_CMD:   if (cmd_ready) phase_d = PH_RSP;
                PH_RSP: begin
                    if (rsp_valid) begin
                        if (cur_op == OP_WRITE && rsp_nack) begin
                            err_d      = 1'b1;
                            cfg_done_d = (state_q == ST_CFG);
                            state_d    = ST_ABORT;
                            phase_d    = PH_SETUP;
                            step_d     = 3'd0;
                        end else begin
                            if (cur_op == OP_READ_ACK)  msb_d = rsp_data;
                            if (cur_op == OP_READ_NACK) lsb_d = rsp_data;
                            if (step_q == seq_last(state_q)) begin
                                temp_valid_d = (state_q == ST_POLL);
                                sample_take  = (state_q == ST_POLL);
                                cfg_done_d   = (state_q == ST_CFG);
                                state_d      = ST_IDLE;
                                phase_d      = PH_SETUP;
                                step_d       = 3'd0;
                            end else begin
                                step_d  = step_q + 3'd1;
                                phase_d = PH_CMD;
                            end
                        end
                    end
                end
                default: phase_d = PH_SETUP;
            endcase
        end

        // A wrap landing on the POLL-entry cycle is a new period and stays pending.
        if (pend_clr) poll_pend_d = 1'b0;
        if (tick)     poll_pend_d = 1'b1;
        if (sample_take) temp_data_d = sample_val;
    end

`ifdef ADT7420_AVG_EN
    logic signed [15:0] hist_q [3];
    logic               hist_full_q;

    // Mean of four samples, floored (arithmetic shift of the 18-bit sum).
    function automatic logic signed [15:0] avg4(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c,
                                                input logic signed [15:0] d);
        logic signed [17:0] sum;
        logic signed [17:0] shifted;
        sum     = 18'(a) + 18'(b) + 18'(c) + 18'(d);
        shifted = sum >>> 2;
        return shifted[15:0];
    endfunction

    assign sample_val = hist_full_q ? avg4(raw, hist_q[0], hist_q[1], hist_q[2]) : raw;

    // History-valid flag: the first sample after reset fills every slot.
    always_ff @(posedge clk) begin
        if (!rst_n)           hist_full_q <= 1'b0;
        else if (sample_take) hist_full_q <= 1'b1;
    end

    // Sample history, newest at index 0.
    always_ff @(posedge clk) begin
        if (sample_take) begin
            hist_q[0] <= raw;
            hist_q[1] <= hist_full_q ? hist_q[0] : raw;
            hist_q[2] <= hist_full_q ? hist_q[1] : raw;
        end
    end
`else
    assign sample_val = raw;
`endif

    // Control state and visible outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            phase_q      <= PH_SETUP;
            step_q       <= 3'd0;
            poll_pend_q  <= 1'b0;
            temp_valid_q <= 1'b0;
            cfg_done_q   <= 1'b0;
            err_q        <= 1'b0;
            temp_data_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            poll_pend_q  <= poll_pend_d;
            temp_valid_q <= temp_valid_d;
            cfg_done_q   <= cfg_done_d;
            err_q        <= err_d;
            temp_data_q  <= temp_data_d;
        end
    end

    // Byte holding registers; always written before they are consumed.
    always_ff @(posedge clk) begin
        msb_q      <= msb_d;
        lsb_q      <= lsb_d;
        cfg_byte_q <= cfg_byte_d;
    end

endmodule

// File: tb/tb_adt7420_poll_ctrl.sv
// tb_adt7420_poll_ctrl: directed sequence with randomized read data, ready
// and response delays, driving a behavioural I2C master and checking the
// command stream and temperature results against expectations built here.
module tb_adt7420_poll_ctrl;

    localparam int INTERVAL = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        rsp_valid, rsp_nack;
    logic [7:0]  rsp_data;
    logic        cfg_req, cfg_done;
    logic [7:0]  cfg_data;
    logic        temp_valid, busy, err;
    logic [15:0] temp_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adt7420_poll_ctrl #(
        .INTERVAL (INTERVAL),
        .I2C_ADDR (7'h4B),
        .CFG_INIT (8'h80)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_nack   (rsp_nack),
        .cfg_req    (cfg_req),
        .cfg_data   (cfg_data),
        .cfg_done   (cfg_done),
        .temp_valid (temp_valid),
        .temp_data  (temp_data),
        .busy       (busy),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;

    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    int          start_q[$];
    logic [15:0] temp_q[$];
    int          err_cnt  = 0;
    int          done_cnt = 0;
    bit          rand_ready = 0;
    bit          hold_low   = 0;
    bit          nack_arm   = 0;
    logic [7:0]  rd_msb = 8'h00;
    logic [7:0]  rd_lsb = 8'h00;

    // Behavioural I2C master plus output monitor, all on the falling edge.
    initial begin : master
        bit         pend;
        int         dly;
        logic       pend_nack;
        logic [7:0] pend_data;
        logic       prev_v;
        pend = 0; dly = 0; pend_nack = 0; pend_data = 0; prev_v = 0;
        cmd_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_nack = 0;
        forever begin
            @(negedge clk);
            rsp_valid = 0; rsp_nack = 0; rsp_data = 0;
            if (!rst_n) pend = 0;
            else if (pend) begin
                if (dly == 0) begin
                    rsp_valid = 1; rsp_nack = pend_nack; rsp_data = pend_data; pend = 0;
                end else dly--;
            end
            cmd_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (rst_n && cmd_valid && cmd_ready) begin
                log_q.push_back({cmd_op, cmd_data});
                pend      = 1;
                dly       = $urandom_range(0, 2);
                pend_nack = (cmd_op == 3'd3) && nack_arm && (cmd_data == 8'h96);
                if (pend_nack) nack_arm = 0;
                pend_data = (cmd_op == 3'd4) ? rd_msb : (cmd_op == 3'd5) ? rd_lsb : 8'h00;
            end
            if (rst_n && cmd_valid && !prev_v && cmd_op == 3'd1) start_q.push_back(cyc);
            prev_v = cmd_valid;
            if (temp_valid) temp_q.push_back(temp_data);
            if (err)        err_cnt++;
            if (cfg_done)   done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected byte streams, written straight from the bus protocol.
    task automatic push_cfg(input logic [7:0] b);
        exp_q.push_back({3'd1, 8'h00});
        exp_q.push_back({3'd3, 8'h96});
        exp_q.push_back({3'd3, 8'h03});
        exp_q.push_back({3'd3, b});
        exp_q.push_back({3'd6, 8'h00});
    endtask

    task automatic push_poll();
        exp_q.push_back({3'd1, 8'h00});
        exp_q.push_back({3'd3, 8'h96});
        exp_q.push_back({3'd3, 8'h00});
        exp_q.push_back({3'd2, 8'h00});
        exp_q.push_back({3'd3, 8'h97});
        exp_q.push_back({3'd4, 8'h00});
        exp_q.push_back({3'd5, 8'h00});
        exp_q.push_back({3'd6, 8'h00});
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

`ifdef ADT7420_AVG_EN
    int hist[$];
`endif
    // Reference temperature: raw reading, or floored mean of the last four.
    task automatic model_sample(input logic [15:0] rawv, output logic [15:0] expv);
`ifdef ADT7420_AVG_EN
        int s, sum;
        s = $signed(rawv);
        if (hist.size() == 0) repeat (4) hist.push_back(s);
        else begin
            void'(hist.pop_front());
            hist.push_back(s);
        end
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        expv = 16'(sum >>> 2);
`else
        expv = rawv;
`endif
    endtask

    task automatic model_reset();
`ifdef ADT7420_AVG_EN
        hist.delete();
`endif
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic wait_temp(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (temp_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_valid"},  cmd_valid, 0);
        chk({tag, "_cmd_op"},     cmd_op, 0);
        chk({tag, "_cmd_data"},   cmd_data, 0);
        chk({tag, "_cfg_done"},   cfg_done, 0);
        chk({tag, "_temp_valid"}, temp_valid, 0);
        chk({tag, "_temp_data"},  temp_data, 0);
        chk({tag, "_busy"},       busy, 1);
        chk({tag, "_err"},        err, 0);
    endtask

    // One complete poll with the given sensor bytes; checks stream and value.
    task automatic run_poll(input string tag, input logic [7:0] m, input logic [7:0] l);
        bit          ok;
        int          n;
        logic [15:0] expv;
        rd_msb = m; rd_lsb = l;
        n = temp_q.size();
        wait_temp(n + 1, 400, ok);
        chk({tag, "_done"}, ok, 1);
        push_poll();
        cmp_log(tag);
        model_sample({m, l}, expv);
        if (ok) chk({tag, "_temp"}, temp_q[$], expv);
    endtask

    initial begin : main
        bit          ok;
        int          s, n, e;
        logic [15:0] held;
        bit          stable;

        rst_n = 0; cfg_req = 0; cfg_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        log_q.delete(); start_q.delete();
        rst_n = 1;

        // Configuration after reset
        wait_idle(300, ok);
        chk("init_done", ok, 1);
        push_cfg(8'h80);
        cmp_log("init");
        chk("init_busy", busy, 0);

        // Fixed-value polls and their spacing
        run_poll("poll_pos", 8'h0A, 8'h40);
        run_poll("poll_neg", 8'hF5, 8'hC0);
        chk("poll_space", start_q[$] - start_q[$-1], INTERVAL);

        // Random readings with a randomly stalling master
        rand_ready = 1;
        for (int k = 0; k < 4; k++)
            run_poll($sformatf("poll_rnd%0d", k), 8'($urandom), 8'($urandom));
        rand_ready = 0;

        // Host write requested on the tick cycle
        s = start_q[$];
        while (cyc < s + INTERVAL - 3) @(negedge clk);
        chk("cfg_align", cyc, s + INTERVAL - 3);
        n = done_cnt;
        cfg_req = 1; cfg_data = 8'h40;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cfg_done) begin ok = 1; break; end
        end
        cfg_req = 0;
        chk("cfg_done_seen", ok, 1);
        push_cfg(8'h40);
        rd_msb = 8'h12; rd_lsb = 8'h34;
        wait_temp(temp_q.size() + 1, 400, ok);
        chk("cfg_poll_done", ok, 1);
        push_poll();
        cmp_log("cfg_then_poll");
        begin
            logic [15:0] expv;
            model_sample(16'h1234, expv);
            if (ok) chk("cfg_poll_temp", temp_q[$], expv);
        end
        chk("cfg_done_once", done_cnt, n + 1);
        run_poll("poll_after_cfg", 8'h05, 8'h80);
        chk("no_tick_lost", start_q[$], s + 2 * INTERVAL);

        // Address NACK during a poll
        n = temp_q.size(); e = err_cnt; held = temp_data;
        nack_arm = 1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) begin ok = 1; break; end
        end
        chk("nack_err_seen", ok, 1);
        wait_idle(100, ok);
        chk("nack_idle", ok, 1);
        exp_q.push_back({3'd1, 8'h00});
        exp_q.push_back({3'd3, 8'h96});
        exp_q.push_back({3'd6, 8'h00});
        cmp_log("nack");
        chk("nack_err_cnt", err_cnt, e + 1);
        chk("nack_no_temp", temp_q.size(), n);
        chk("nack_temp_hold", temp_data, held);
        run_poll("poll_after_nack", 8'($urandom), 8'($urandom));

        // Stalled master, then reset mid-poll
        n = start_q.size();
        hold_low = 1;
        for (int i = 0; i < 300 && start_q.size() == n; i++) @(negedge clk);
        chk("stall_started", start_q.size(), n + 1);
        stable = 1;
        repeat (50) begin
            @(negedge clk);
            if (!(cmd_valid === 1'b1 && cmd_op === 3'd1 && cmd_data === 8'h00)) stable = 0;
        end
        chk("stall_hold", stable, 1);
        rst_n = 0;
        @(negedge clk);
        chk_reset("midrst");
        hold_low = 0;
        @(negedge clk);
        log_q.delete();
        model_reset();
        rst_n = 1;
        wait_idle(300, ok);
        chk("reinit_done", ok, 1);
        push_cfg(8'h80);
        cmp_log("reinit");
        run_poll("poll_after_rst", 8'h0A, 8'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
